// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin fp16 add/sub array scheduler.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package alu_sched_pkg;

  // Opcode carried on alu_op; the encoding matches the array's op input.
  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  localparam int ALU_LAT_DEFAULT = 3;
  localparam int NUM_REQ_DEFAULT = 4;

  // Requester tag at the default requester count. alu_sched derives its own
  // tag width from num_req so that other configurations stay consistent.
  typedef logic [$clog2(NUM_REQ_DEFAULT)-1:0] tag_t;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Round-robin arbiter: the first asserted request at or after ptr wins.
// Latency: purely combinational, no state (the pointer lives in the parent).
// Backpressure: none; gnt is one-hot or zero and only covers asserted requests.
//
// Ports:
//   req     - request vector
//   ptr     - index with highest priority this cycle
//   gnt     - one-hot grant (zero when no request is asserted)
//   gnt_idx - encoded index of the grant (0 when gnt is zero)
module rr_arbiter #(
  parameter int n = 4,
  localparam int w = (n > 1) ? $clog2(n) : 1
) (
  input  logic [n-1:0] req,
  input  logic [w-1:0] ptr,
  output logic [n-1:0] gnt,
  output logic [w-1:0] gnt_idx
);

  logic         found;
  logic [w-1:0] idx;

  // Walk the requests starting at ptr, wrapping modulo n; first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < n; k++) begin
      idx = w'((int'(ptr) + k) % n);
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one fp16 vector add/sub array among requesters.
// Latency: transfer to rsp_valid is alu_lat+2 cycles; one operation per cycle sustained.
// Backpressure: req_ready grants one requester per cycle; responses have no backpressure.
//
// Ports:
//   clk, rst_n                 - clock; synchronous reset, active HIGH (1 = reset)
//   req_valid/req_ready        - per-requester handshake, req_ready one-hot or zero
//   req_op, req_a, req_b       - per-requester opcode and operand vectors
//   alu_a_vec/alu_b_vec/alu_op - registered operands/opcode to the array
//   alu_issue                  - the alu_* outputs carry a live operation this cycle
//   alu_valid_i, alu_res_i     - array result strobe and result vector
//   rsp_valid, rsp_data        - one-hot result strobe and shared result bus
//   err_o                      - sticky: alu_valid_i disagreed with the tag pipeline
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int data_width = 16,
  parameter int dim_size   = 128,
  parameter int num_req    = 4,
  parameter int alu_lat    = ALU_LAT_DEFAULT
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [num_req-1:0]                                req_valid,
  output logic [num_req-1:0]                                req_ready,
  input  logic [num_req-1:0]                                req_op,
  input  logic [num_req-1:0][dim_size-1:0][data_width-1:0] req_a,
  input  logic [num_req-1:0][dim_size-1:0][data_width-1:0] req_b,
  output logic [dim_size-1:0][data_width-1:0]               alu_a_vec,
  output logic [dim_size-1:0][data_width-1:0]               alu_b_vec,
  output logic                                              alu_op,
  output logic                                              alu_issue,
  input  logic                                              alu_valid_i,
  input  logic [dim_size-1:0][data_width-1:0]               alu_res_i,
  output logic [num_req-1:0]                                rsp_valid,
  output logic [dim_size-1:0][data_width-1:0]               rsp_data,
  output logic                                              err_o
);

  localparam int tag_w = (num_req > 1) ? $clog2(num_req) : 1;

  logic [tag_w-1:0]              rr_ptr;
  logic [tag_w-1:0]              gnt_idx;
  logic [tag_w-1:0]              issue_tag;
  logic [num_req-1:0]            gnt;
  logic                          xfer;
  logic [alu_lat-1:0]            stg_vld;
  logic [alu_lat-1:0][tag_w-1:0] stg_tag;
  logic                          head_vld;
  logic [tag_w-1:0]              head_tag;

  rr_arbiter #(.n(num_req)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // No grant is offered while reset is held, so nothing can transfer then.
  assign req_ready = rst_n ? '0 : gnt;
  assign xfer      = |(req_valid & req_ready);

  assign head_vld  = stg_vld[alu_lat-1];
  assign head_tag  = stg_tag[alu_lat-1];

  // Issue stage: pointer, operand registers and the issue strobe. The tag of
  // the live issue travels alongside so stage 0 can capture it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rr_ptr    <= '0;
      alu_issue <= 1'b0;
      issue_tag <= '0;
      alu_op    <= 1'b0;
      alu_a_vec <= '0;
      alu_b_vec <= '0;
    end else begin
      alu_issue <= xfer;
      if (xfer) begin
        rr_ptr    <= (gnt_idx == tag_w'(num_req - 1)) ? '0 : gnt_idx + tag_w'(1);
        issue_tag <= gnt_idx;
        alu_op    <= req_op[gnt_idx];
        alu_a_vec <= req_a[gnt_idx];
        alu_b_vec <= req_b[gnt_idx];
      end
    end
  end

  // Shadow of the array pipeline: stage 0 captures the issue-cycle strobe, so
  // the head lines up with the cycle alu_valid_i is due.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      stg_vld <= '0;
      stg_tag <= '0;
    end else begin
      stg_vld[0] <= alu_issue;
      stg_tag[0] <= issue_tag;
      for (int s = 1; s < alu_lat; s++) begin
        stg_vld[s] <= stg_vld[s-1];
        stg_tag[s] <= stg_tag[s-1];
      end
    end
  end

  // Response and error. The head retires every cycle by shifting; a strobe
  // disagreement sets the sticky error and suppresses the response.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      err_o     <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (head_vld && alu_valid_i) begin
        rsp_valid <= {{(num_req-1){1'b0}}, 1'b1} << head_tag;
        rsp_data  <= alu_res_i;
      end
      if (head_vld != alu_valid_i) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int N   = 4;
  localparam int D   = 128;
  localparam int W   = 16;
  localparam int LAT = 3;

  typedef logic [D-1:0][W-1:0] vec_t;
  typedef struct packed {
    logic op;
    vec_t a;
    vec_t b;
    vec_t res;
  } op_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [N-1:0]              req_valid, req_ready, req_op;
  logic [N-1:0][D-1:0][W-1:0] req_a, req_b;
  vec_t                      alu_a_vec, alu_b_vec, alu_res_i, rsp_data;
  logic                      alu_op, alu_issue, alu_valid_i, err_o;
  logic [N-1:0]              rsp_valid;

  alu_sched #(.data_width(W), .dim_size(D), .num_req(N), .alu_lat(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a_vec(alu_a_vec), .alu_b_vec(alu_b_vec), .alu_op(alu_op),
    .alu_issue(alu_issue), .alu_valid_i(alu_valid_i), .alu_res_i(alu_res_i),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Requester side
  op_t          pend [N];
  logic [N-1:0] pend_vld = '0;
  int           remaining [N];

  // Reference model state
  int           mptr = 0;
  logic         exp_issue = 1'b0;
  vec_t         last_a = '0, last_b = '0;
  logic         last_op = 1'b0;
  logic [N-1:0] exp_rsp_vld = '0;
  vec_t         exp_rsp_dat = '0;
  logic         exp_err = 1'b0;
  op_t          head_op [int];
  int           head_tag [int];

  // Array stand-in
  vec_t alu_at [int];
  logic early_next = 1'b0;

  // Observation logs
  int          grant_log[$], grant_cyc[$], rsp_tag[$], rsp_cyc[$];
  logic [15:0] rsp_d0[$];

  function automatic logic [15:0] i2h(int v);
    int m, e;
    logic s;
    if (v == 0) return 16'h0000;
    s = (v < 0);
    m = s ? -v : v;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    return {s, 5'(e + 15), 10'((m << (10 - e)) & 'h3ff)};
  endfunction

  function automatic int h2i(logic [15:0] h);
    int e, m, v;
    if (h[14:0] == 15'd0) return 0;
    e = int'(h[14:10]) - 15;
    m = int'({1'b1, h[9:0]});
    if (e < 0) v = 0;
    else if (e > 10) v = m << (e - 10);
    else v = m >> (10 - e);
    return h[15] ? -v : v;
  endfunction

  function automatic op_t mk_op(logic op, int ia, int ib, bit vary);
    op_t r;
    int x, y;
    r.op = op;
    for (int l = 0; l < D; l++) begin
      x = ia + (vary ? (l & 3) : 0);
      y = ib + (vary ? ((l >> 2) & 3) : 0);
      r.a[l]   = i2h(x);
      r.b[l]   = i2h(y);
      r.res[l] = i2h(op ? x - y : x + y);
    end
    return r;
  endfunction

  function automatic op_t rand_op();
    return mk_op(1'($urandom_range(0, 1)), int'($urandom_range(1, 500)),
                 int'($urandom_range(1, 500)), 1'b1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_vec(string tag, vec_t obs, vec_t exp);
    int l;
    l = 0;
    for (int i = D - 1; i >= 0; i--) if (obs[i] !== exp[i]) l = i;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d lane %0d observed=%h expected=%h", tag, cyc, l, obs[l], exp[l]);
    end
  endtask

  task automatic clear_logs();
    grant_log.delete(); grant_cyc.delete();
    rsp_tag.delete(); rsp_cyc.delete(); rsp_d0.delete();
  endtask

  task automatic consume(int g);
    if (remaining[g] > 0) begin
      pend[g] = rand_op();
      remaining[g]--;
    end else begin
      pend_vld[g] = 1'b0;
    end
  endtask

  // One clock cycle: drive, sample at the falling edge, advance the model.
  task automatic tick();
    logic [N-1:0] exp_rdy;
    int           g;
    logic         head_v;
    vec_t         r;

    req_valid = pend_vld;
    for (int i = 0; i < N; i++) begin
      req_op[i] = pend[i].op;
      req_a[i]  = pend[i].a;
      req_b[i]  = pend[i].b;
    end
    alu_valid_i = alu_at.exists(cyc);
    if (alu_valid_i) begin
      alu_res_i = alu_at[cyc];
      alu_at.delete(cyc);
    end else begin
      alu_res_i[0] = 16'($urandom);
    end

    @(negedge clk);

    chk("alu_issue", alu_issue, exp_issue);
    chk_vec("alu_a_vec", alu_a_vec, last_a);
    chk_vec("alu_b_vec", alu_b_vec, last_b);
    chk("alu_op", alu_op, last_op);
    chk("rsp_valid", rsp_valid, exp_rsp_vld);
    chk_vec("rsp_data", rsp_data, exp_rsp_dat);
    chk("err_o", err_o, exp_err);

    g = -1;
    exp_rdy = '0;
    if (!rst_n) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && pend_vld[(mptr + k) % N]) g = (mptr + k) % N;
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    chk("req_ready", req_ready, exp_rdy);

    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        grant_log.push_back(i);
        grant_cyc.push_back(cyc);
      end
      if (rsp_valid[i]) begin
        rsp_tag.push_back(i);
        rsp_cyc.push_back(cyc);
        rsp_d0.push_back(rsp_data[0]);
      end
    end

    // Array stand-in: returns operand sum/difference alu_lat cycles after issue.
    if (alu_issue === 1'b1) begin
      for (int l = 0; l < D; l++)
        r[l] = i2h(alu_op ? h2i(alu_a_vec[l]) - h2i(alu_b_vec[l])
                          : h2i(alu_a_vec[l]) + h2i(alu_b_vec[l]));
      alu_at[cyc + (early_next ? LAT - 1 : LAT)] = r;
      early_next = 1'b0;
    end

    if (rst_n) begin
      mptr = 0;
      exp_issue = 1'b0;
      last_a = '0; last_b = '0; last_op = 1'b0;
      exp_rsp_vld = '0; exp_rsp_dat = '0;
      exp_err = 1'b0;
      head_op.delete(); head_tag.delete();
    end else begin
      head_v = head_op.exists(cyc);
      exp_rsp_vld = '0;
      if (head_v && alu_valid_i) begin
        exp_rsp_vld = N'(1) << head_tag[cyc];
        exp_rsp_dat = head_op[cyc].res;
      end
      if (head_v != alu_valid_i) exp_err = 1'b1;
      if (head_v) begin
        head_op.delete(cyc);
        head_tag.delete(cyc);
      end
      exp_issue = (g >= 0);
      if (g >= 0) begin
        last_a  = pend[g].a;
        last_b  = pend[g].b;
        last_op = pend[g].op;
        head_op[cyc + 1 + LAT]  = pend[g];
        head_tag[cyc + 1 + LAT] = g;
        mptr = (g + 1) % N;
        consume(g);
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b1;
    req_valid   = '0;
    req_op      = '0;
    req_a       = '0;
    req_b       = '0;
    alu_valid_i = 1'b0;
    alu_res_i   = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = '0;
      remaining[i] = 0;
    end
    @(posedge clk);
    #1;

    // Reset state
    ticks(2);
    rst_n = 1'b0;

    // Single request: requester 2, 1.0 + 2.0
    clear_logs();
    pend[2] = mk_op(ALU_ADD, 1, 2, 1'b0);
    pend_vld[2] = 1'b1;
    ticks(10);
    chk("single_grants", grant_log.size(), 1);
    chk("single_rsps", rsp_tag.size(), 1);
    if (grant_log.size() == 1 && rsp_tag.size() == 1) begin
      chk("single_tag", rsp_tag[0], 2);
      chk("single_latency", rsp_cyc[0] - grant_cyc[0], 5);
      chk("single_data", rsp_d0[0], 16'h4200);
    end

    // Contention from reset: 0 then 3
    reset_pulse();
    clear_logs();
    pend[0] = rand_op(); pend_vld[0] = 1'b1;
    pend[3] = rand_op(); pend_vld[3] = 1'b1;
    ticks(10);
    chk("cont_grants", grant_log.size(), 2);
    chk("cont_rsps", rsp_tag.size(), 2);
    if (grant_log.size() == 2 && rsp_tag.size() == 2) begin
      chk("cont_first", grant_log[0], 0);
      chk("cont_second", grant_log[1], 3);
      chk("cont_rsp_order", {rsp_tag[0][15:0], rsp_tag[1][15:0]}, {16'd0, 16'd3});
      chk("cont_rsp_gap", rsp_cyc[1] - rsp_cyc[0], 1);
    end

    // Saturation: three ops per requester, all continuously valid
    reset_pulse();
    clear_logs();
    for (int i = 0; i < N; i++) begin
      pend[i] = rand_op();
      pend_vld[i] = 1'b1;
      remaining[i] = 2;
    end
    pend[1] = mk_op(ALU_SUB, 2, 1, 1'b0);
    ticks(20);
    chk("sat_grants", grant_log.size(), 12);
    chk("sat_rsps", rsp_tag.size(), 12);
    for (int k = 0; k < 12; k++) begin
      if (k < grant_log.size() && k < rsp_tag.size()) begin
        chk("sat_grant_seq", grant_log[k], k % N);
        chk("sat_rsp_tag", rsp_tag[k], k % N);
        chk("sat_rsp_b2b", rsp_cyc[k] - rsp_cyc[0], k);
      end
    end
    if (rsp_d0.size() > 1) chk("sat_sub_data", rsp_d0[1], 16'h3C00);

    // Reset mid-flight: three ops in flight, pointer left at 3
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      pend[i] = rand_op();
      pend_vld[i] = 1'b1;
    end
    ticks(3);
    reset_pulse();
    ticks(7);
    chk("midrst_no_rsp", rsp_tag.size(), 0);
    chk("midrst_err_after", err_o, 1);
    pend[3] = rand_op(); pend_vld[3] = 1'b1;
    pend[0] = rand_op(); pend_vld[0] = 1'b1;
    ticks(10);
    chk("midrst_regrants", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      chk("midrst_ptr_restart", grant_log[3], 0);
      chk("midrst_ptr_next", grant_log[4], 3);
    end
    reset_pulse();
    chk("err_cleared", err_o, 0);

    // Latency mismatch: array strobe one cycle early
    clear_logs();
    early_next = 1'b1;
    pend[1] = rand_op(); pend_vld[1] = 1'b1;
    ticks(10);
    chk("mis_err", err_o, 1);
    chk("mis_no_rsp", rsp_tag.size(), 0);
    reset_pulse();

    // Idle gap on requester 1
    clear_logs();
    pend[1] = rand_op(); pend_vld[1] = 1'b1;
    tick();
    tick();
    pend[1] = rand_op(); pend_vld[1] = 1'b1;
    ticks(10);
    chk("gap_grants", grant_log.size(), 2);
    chk("gap_rsps", rsp_tag.size(), 2);
    if (grant_log.size() == 2) begin
      chk("gap_grant0", grant_log[0], 1);
      chk("gap_grant1", grant_log[1], 1);
      chk("gap_spacing", grant_cyc[1] - grant_cyc[0], 2);
    end

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_vld[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = rand_op();
          pend_vld[i] = 1'b1;
        end
      end
      tick();
    end
    ticks(20);
    chk("rand_err", err_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
